axis_pkt_arbiter_2: RTL and testbench
=====================================

// Module: axis_pkt_arbiter_2
// PURPOSE
//  Packet-level round-robin arbiter sharing one AXI-Stream output between two sources.
//  Replaces the external sel of the 2:1 stream mux: grants a source for a whole packet, switches only on tlast.
//  Enforces a max packet length by truncating oversized packets, and keeps per-source packet counters.
//  Sits in front of the shared downstream stream consumer; registered output (one-beat pipeline slice).
// PARAMETERS
//  DW        8    data width of s1/s2/m tdata
//  MAX_BEATS 256  max beats per packet before forced truncation (>=2)
//  CNT_W     16   width of per-source packet counters
// PORTS
//  clk        in   1      clock
//  rst        in   1      reset, synchronous, active-high
//  s1_tdata   in   DW     source 1 data
//  s1_tvalid  in   1      source 1 valid
//  s1_tlast   in   1      source 1 end of packet
//  s1_tready  out  1      source 1 ready
//  s2_tdata   in   DW     source 2 data
//  s2_tvalid  in   1      source 2 valid
//  s2_tlast   in   1      source 2 end of packet
//  s2_tready  out  1      source 2 ready
//  m_tdata    out  DW     output data (registered)
//  m_tvalid   out  1      output valid (registered)
//  m_tlast    out  1      output end of packet (registered)
//  m_tready   in   1      downstream ready
//  grant      out  2      one-hot current owner {s2,s1}; 00 when idle
//  trunc_err  out  1      1-cycle pulse when a packet is truncated
//  pkt_cnt1   out  CNT_W  packets forwarded from s1 (wraps)
//  pkt_cnt2   out  CNT_W  packets forwarded from s2 (wraps)
// BEHAVIOUR
//  Reset: state IDLE, grant=00, rr_last=S2 (s1 wins first tie), beat_cnt=0, m_tvalid=0, m_tdata=0, m_tlast=0,
//   trunc_err=0, pkt_cnt1/2=0, s1/s2_tready=0. Reset mid-packet discards the slice beat and the packet; no recovery.
//  Slice: load = owner tvalid & owner tready; owner tready = (!m_tvalid | m_tready) in BUSY, 1 in FLUSH.
//   Non-owner tready=0 always; both tready=0 in IDLE. Latency input->m_* 1 cycle; 1 beat/cycle sustained.
//   m_tvalid clears on m_tready when no load that cycle. m_* stable while m_tvalid & !m_tready.
//  IDLE: no beat accepted. If only s1 (s2) valid -> grant it. Both valid -> grant the one != rr_last.
//   Next state BUSY, grant set next cycle (one bubble cycle per packet).
//  BUSY: each accepted beat: beat_cnt++ and forwarded.
//   Accepted beat with tlast=1 -> IDLE, rr_last<=owner, beat_cnt<=0, pkt_cnt[owner]++.
//   Accepted beat with tlast=0 & beat_cnt==MAX_BEATS-1 -> forwarded with m_tlast forced 1, trunc_err pulse,
//    pkt_cnt[owner]++, -> FLUSH.
//   tlast=1 exactly at beat MAX_BEATS -> normal completion, no trunc_err.
//  FLUSH: owner beats accepted and dropped (never forwarded) until owner tlast accepted -> IDLE, rr_last<=owner.
//  Counters wrap 2^CNT_W-1 -> 0. grant holds for the whole BUSY/FLUSH period. Source tvalid drop mid-packet just stalls.
// STRUCTURE
//  Package axis_arb_pkg: typedef enum logic[1:0] {ARB_IDLE, ARB_BUSY, ARB_FLUSH} arb_state_t;
//   localparams SRC_S1=0, SRC_S2=1; grant one-hot encodings.
//  Sub-module axis_reg_slice #(DW): 1-entry registered valid/ready slice (load, tdata, tlast, m_* , m_tready).
//  Top holds FSM, rr_last, beat_cnt ($clog2(MAX_BEATS+1) bits), counters, tready/mux logic.
// TESTING
//  Only s1 sends 3-beat pkt A1..A3, m_tready=1 -> m_* = A1,A2,A3 (tlast on A3), 1-cycle lag, pkt_cnt1=1, grant=01.
//  s1,s2 both valid continuously with 2-beat pkts -> packets alternate s1,s2,s1,s2; never interleave mid-packet.
//  m_tready toggles 1,0,1,0 during 4-beat pkt -> no beat lost/duplicated; m_* held while stalled.
//  MAX_BEATS=4, s2 sends 6-beat pkt -> 4 beats out, tlast on 4th, trunc_err 1 cycle, beats 5-6 dropped, IDLE after.
//  MAX_BEATS=4, 4-beat pkt with tlast on beat 4 -> no trunc_err, pkt_cnt increments once.
//  rst asserted after beat 2 of s1 pkt -> next cycle m_tvalid=0, grant=00, counters 0; s2 pkt then granted cleanly.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared types and encodings for the packet arbiter
package axis_arb_pkg;

   typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_FLUSH} arb_state_t;

   localparam int SRC_S1 = 0;
   localparam int SRC_S2 = 1;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_S1   = 2'b01;
   localparam logic [1:0] GRANT_S2   = 2'b10;

endpackage

// File: rtl/axis_reg_slice.sv
// rtl/axis_reg_slice.sv - one-entry registered valid/ready output slice
module axis_reg_slice #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [DW-1:0] s_tdata,
   input  logic          s_tlast,
   output logic          s_ready,
   output logic [DW-1:0] m_tdata,
   output logic          m_tvalid,
   output logic          m_tlast,
   input  logic          m_tready
);

   assign s_ready = !m_tvalid || m_tready;

   always_ff @(posedge clk) begin
      if (rst) begin
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         m_tlast  <= 1'b0;
      end else if (load) begin
         m_tvalid <= 1'b1;
         m_tdata  <= s_tdata;
         m_tlast  <= s_tlast;
      end else if (m_tready) begin
         m_tvalid <= 1'b0;
      end
   end

endmodule

// File: rtl/axis_pkt_arbiter_2.sv
// rtl/axis_pkt_arbiter_2.sv - packet-level round-robin 2:1 stream arbiter
import axis_arb_pkg::*;

module axis_pkt_arbiter_2 #(
   parameter int DW        = 8,
   parameter int MAX_BEATS = 256,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DW-1:0]    s1_tdata,
   input  logic             s1_tvalid,
   input  logic             s1_tlast,
   output logic             s1_tready,
   input  logic [DW-1:0]    s2_tdata,
   input  logic             s2_tvalid,
   input  logic             s2_tlast,
   output logic             s2_tready,
   output logic [DW-1:0]    m_tdata,
   output logic             m_tvalid,
   output logic             m_tlast,
   input  logic             m_tready,
   output logic [1:0]       grant,
   output logic             trunc_err,
   output logic [CNT_W-1:0] pkt_cnt1,
   output logic [CNT_W-1:0] pkt_cnt2
);

   localparam int BW = $clog2(MAX_BEATS + 1);
   localparam logic [BW-1:0] LAST_IDX = BW'(MAX_BEATS - 1);

   arb_state_t    state, state_nxt;
   logic [1:0]    grant_nxt;
   logic          rr_last, rr_last_nxt;
   logic [BW-1:0] beat_cnt, beat_cnt_nxt;
   logic          owner_s2;
   logic [DW-1:0] own_tdata;
   logic          own_tvalid, own_tlast, own_tready;
   logic          slice_ready, load, fwd_last, trunc_nxt, pkt_inc;

   assign owner_s2   = grant[1];
   assign own_tdata  = owner_s2 ? s2_tdata  : s1_tdata;
   assign own_tvalid = owner_s2 ? s2_tvalid : s1_tvalid;
   assign own_tlast  = owner_s2 ? s2_tlast  : s1_tlast;
   assign s1_tready  = own_tready && grant[0];
   assign s2_tready  = own_tready && grant[1];

   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant;
      rr_last_nxt  = rr_last;
      beat_cnt_nxt = beat_cnt;
      own_tready   = 1'b0;
      load         = 1'b0;
      fwd_last     = own_tlast;
      trunc_nxt    = 1'b0;
      pkt_inc      = 1'b0;
      case (state)
         ARB_IDLE: begin
            // rr_last is 1 when s2 owned last, so s1 takes a tie
            if (s1_tvalid && (!s2_tvalid || rr_last)) begin
               grant_nxt = GRANT_S1;
               state_nxt = ARB_BUSY;
            end else if (s2_tvalid) begin
               grant_nxt = GRANT_S2;
               state_nxt = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            own_tready = slice_ready;
            if (own_tvalid && slice_ready) begin
               load = 1'b1;
               if (own_tlast) begin
                  state_nxt    = ARB_IDLE;
                  grant_nxt    = GRANT_NONE;
                  rr_last_nxt  = owner_s2;
                  beat_cnt_nxt = '0;
                  pkt_inc      = 1'b1;
               end else if (beat_cnt == LAST_IDX) begin
                  fwd_last     = 1'b1;
                  trunc_nxt    = 1'b1;
                  pkt_inc      = 1'b1;
                  beat_cnt_nxt = '0;
                  state_nxt    = ARB_FLUSH;
               end else begin
                  beat_cnt_nxt = beat_cnt + 1'b1;
               end
            end
         end
         ARB_FLUSH: begin
            // drain the rest of an oversized packet without forwarding it
            own_tready = 1'b1;
            if (own_tvalid && own_tlast) begin
               state_nxt   = ARB_IDLE;
               grant_nxt   = GRANT_NONE;
               rr_last_nxt = owner_s2;
            end
         end
         default: begin
            state_nxt = ARB_IDLE;
            grant_nxt = GRANT_NONE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ARB_IDLE;
         grant     <= GRANT_NONE;
         rr_last   <= 1'(SRC_S2);
         beat_cnt  <= '0;
         trunc_err <= 1'b0;
         pkt_cnt1  <= '0;
         pkt_cnt2  <= '0;
      end else begin
         state     <= state_nxt;
         grant     <= grant_nxt;
         rr_last   <= rr_last_nxt;
         beat_cnt  <= beat_cnt_nxt;
         trunc_err <= trunc_nxt;
         if (pkt_inc && owner_s2) pkt_cnt2 <= pkt_cnt2 + 1'b1;
         if (pkt_inc && !owner_s2) pkt_cnt1 <= pkt_cnt1 + 1'b1;
      end
   end

   axis_reg_slice #(.DW(DW)) u_slice (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .s_tdata  (own_tdata),
      .s_tlast  (fwd_last),
      .s_ready  (slice_ready),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tlast  (m_tlast),
      .m_tready (m_tready)
   );

endmodule

// File: tb/tb_axis_pkt_arbiter_2.sv
// tb/tb_axis_pkt_arbiter_2.sv - scoreboard bench for axis_pkt_arbiter_2
module tb_axis_pkt_arbiter_2;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  s1_tdata, s2_tdata, m_tdata;
   logic        s1_tvalid, s1_tlast, s1_tready;
   logic        s2_tvalid, s2_tlast, s2_tready;
   logic        m_tvalid, m_tlast, m_tready;
   logic [1:0]  grant;
   logic        trunc_err;
   logic [15:0] pkt_cnt1, pkt_cnt2;

   int errors = 0;
   int checks = 0;
   int trunc_cnt = 0;
   int acc1 = 0;
   logic [8:0] exp_q[$];

   always #5 clk = ~clk;

   axis_pkt_arbiter_2 #(.DW(8), .MAX_BEATS(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
      .s2_tdata(s2_tdata), .s2_tvalid(s2_tvalid), .s2_tlast(s2_tlast), .s2_tready(s2_tready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
      .grant(grant), .trunc_err(trunc_err), .pkt_cnt1(pkt_cnt1), .pkt_cnt2(pkt_cnt2)
   );

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), base + 8'(i)});
   endtask

   task automatic drive(input bit src2, input bit v, input logic [7:0] d, input bit l);
      if (src2) begin
         s2_tvalid = v; s2_tdata = d; s2_tlast = l;
      end else begin
         s1_tvalid = v; s1_tdata = d; s1_tlast = l;
      end
   endtask

   // presents one beat at a time; abandons the packet if rst is raised
   task automatic send_pkt(input bit src2, input logic [7:0] base, input int n);
      bit got, aborted;
      aborted = 0;
      for (int i = 0; i < n && !aborted; i++) begin
         drive(src2, 1'b1, base + 8'(i), (i == n - 1));
         got = 0;
         for (int c = 0; c < 200 && !got && !aborted; c++) begin
            @(negedge clk);
            if (rst) aborted = 1;
            else if (src2 ? s2_tready : s1_tready) got = 1;
         end
         if (!got && !aborted) begin
            checks++; errors++;
            $display("FAIL accept_timeout: src2=%0d beat %0d not accepted, expected acceptance", src2, i);
            aborted = 1;
         end
         if (got) begin
            @(posedge clk); #1;
            if (!src2) acc1++;
         end
      end
      drive(src2, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic wait_drain();
      for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(negedge clk);
      @(negedge clk);
      chk("drain", exp_q.size(), 0);
   endtask

   initial begin : monitor
      bit prev_stall;
      logic [8:0] prev_beat, e;
      prev_stall = 0;
      prev_beat  = '0;
      forever begin
         @(negedge clk);
         if (prev_stall && !rst) begin
            checks++;
            if (!m_tvalid || {m_tlast, m_tdata} !== prev_beat) begin
               errors++;
               $display("FAIL hold: got v=%0d %0h expected v=1 %0h", m_tvalid, {m_tlast, m_tdata}, prev_beat);
            end
         end
         if (m_tvalid && m_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL beat: got unexpected %0h expected none", {m_tlast, m_tdata});
            end else begin
               e = exp_q.pop_front();
               if ({m_tlast, m_tdata} !== e) begin
                  errors++;
                  $display("FAIL beat: got %0h expected %0h", {m_tlast, m_tdata}, e);
               end
            end
         end
         if (trunc_err) begin
            trunc_cnt++;
            checks++;
            if (!(m_tvalid && m_tlast)) begin
               errors++;
               $display("FAIL trunc_last: got v=%0d last=%0d expected 1 1", m_tvalid, m_tlast);
            end
         end
         prev_stall = !rst && m_tvalid && !m_tready;
         prev_beat  = {m_tlast, m_tdata};
      end
   end

   initial begin
      rst = 1'b1; m_tready = 1'b1;
      drive(0, 0, 8'h00, 0);
      drive(1, 0, 8'h00, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_grant", grant, 2'b00);
      chk("rst_cnt1", pkt_cnt1, 0);
      chk("rst_cnt2", pkt_cnt2, 0);
      chk("rst_trunc", trunc_err, 0);
      chk("rst_tready", {s2_tready, s1_tready}, 2'b00);
      @(posedge clk); #1 rst = 1'b0;

      // single 3-beat packet from s1, cycle-exact latency
      push_exp(8'hA1, 3);
      fork
         send_pkt(0, 8'hA1, 3);
         begin
            @(negedge clk);
            chk("t1_idle_grant", grant, 2'b00);
            chk("t1_idle_tready", s1_tready, 0);
            @(negedge clk);
            chk("t1_grant", grant, 2'b01);
            chk("t1_tready", s1_tready, 1);
            chk("t1_no_out_yet", m_tvalid, 0);
            @(negedge clk);
            chk("t1_lag_valid", m_tvalid, 1);
            chk("t1_lag_data", m_tdata, 8'hA1);
         end
      join
      wait_drain();
      chk("t1_cnt1", pkt_cnt1, 1);
      chk("t1_idle_after", grant, 2'b00);

      // both sources busy: rr_last=s1 now, so s2 wins first
      push_exp(8'h41, 2); push_exp(8'h31, 2); push_exp(8'h61, 2); push_exp(8'h51, 2);
      fork
         begin send_pkt(0, 8'h31, 2); send_pkt(0, 8'h51, 2); end
         begin send_pkt(1, 8'h41, 2); send_pkt(1, 8'h61, 2); end
      join
      wait_drain();
      chk("t2_cnt1", pkt_cnt1, 3);
      chk("t2_cnt2", pkt_cnt2, 2);

      // downstream backpressure toggling
      push_exp(8'h91, 4);
      fork
         send_pkt(0, 8'h91, 4);
         begin
            for (int i = 0; i < 12; i++) begin
               @(posedge clk); #1 m_tready = ~m_tready;
            end
            m_tready = 1'b1;
         end
      join
      wait_drain();
      chk("t3_cnt1", pkt_cnt1, 4);

      // oversize s2 packet truncated after 4 beats
      push_exp(8'hB1, 4);
      send_pkt(1, 8'hB1, 6);
      @(negedge clk);
      chk("t4_idle_after_flush", grant, 2'b00);
      wait_drain();
      chk("t4_trunc_cnt", trunc_cnt, 1);
      chk("t4_cnt2", pkt_cnt2, 3);

      // exactly MAX_BEATS beats completes normally
      push_exp(8'hC1, 4);
      send_pkt(0, 8'hC1, 4);
      wait_drain();
      chk("t5_trunc_cnt", trunc_cnt, 1);
      chk("t5_cnt1", pkt_cnt1, 5);

      // reset after beat 2 of an s1 packet
      exp_q.push_back({1'b0, 8'h71});
      exp_q.push_back({1'b0, 8'h72});
      fork
         send_pkt(0, 8'h71, 4);
         begin
            int tgt;
            bit seen;
            tgt = acc1 + 2;
            seen = 0;
            for (int c = 0; c < 200 && !seen; c++) begin
               @(posedge clk); #2;
               if (acc1 >= tgt) seen = 1;
            end
            chk("t6_reached_beat2", seen, 1);
            rst = 1'b1;
         end
      join
      @(negedge clk);
      chk("t6_m_tvalid", m_tvalid, 0);
      chk("t6_grant", grant, 2'b00);
      chk("t6_cnt1", pkt_cnt1, 0);
      chk("t6_cnt2", pkt_cnt2, 0);
      @(posedge clk); #1 rst = 1'b0;
      push_exp(8'h81, 2);
      send_pkt(1, 8'h81, 2);
      wait_drain();
      chk("t6_post_cnt2", pkt_cnt2, 1);
      chk("t6_post_cnt1", pkt_cnt1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
